// File: rtl/gate_ctrl_dt.sv
// -----------------------------------------------------------------------------
// gate_ctrl_dt
//   Inverter gate-output stage between the PWM generator and the gate drivers.
//   A run/fault state machine gates NUM_CH high/low switch pairs. Every
//   high<->low changeover gets a programmable dead time. External faults and
//   shoot-through requests are latched, and while they are latched every gate
//   output is held low.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   en_output_i  level enable for the gate outputs
//   hi_i         high-side commands from PWM (bit0 = U)
//   lo_i         low-side commands from PWM (bit0 = X)
//   dt_cycles_i  dead time in clk cycles (0 behaves as 1)
//   fault_ni     external fault, active-low, asynchronous to clk_i
//   fault_clr_i  one-cycle fault clear request
//   hi_o / lo_o  registered high/low gate drives
//   state_o      00 OFF, 01 RUN, 10 FAULT
//   fault_o      1 while in FAULT
//   fault_src_o  latched cause: bit0 external, bit1 shoot-through
//   st_ch_o      latched channel(s) that requested shoot-through
// -----------------------------------------------------------------------------
module gate_ctrl_dt #(
  parameter int NUM_CH      = 3,
  parameter int DT_W        = 8,
  parameter int ST_FAULT    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_output_i,
  input  logic [NUM_CH-1:0] hi_i,
  input  logic [NUM_CH-1:0] lo_i,
  input  logic [DT_W-1:0]   dt_cycles_i,
  input  logic              fault_ni,
  input  logic              fault_clr_i,
  output logic [NUM_CH-1:0] hi_o,
  output logic [NUM_CH-1:0] lo_o,
  output logic [1:0]        state_o,
  output logic              fault_o,
  output logic [1:0]        fault_src_o,
  output logic [NUM_CH-1:0] st_ch_o
);

  typedef enum logic [1:0] {
    ST_OFF = 2'b00,
    ST_RUN = 2'b01,
    ST_FLT = 2'b10
  } state_e;

  // Side most recently released by a channel; NONE right after RUN entry.
  localparam logic [1:0] SIDE_NONE = 2'b00;
  localparam logic [1:0] SIDE_HI   = 2'b01;
  localparam logic [1:0] SIDE_LO   = 2'b10;

  state_e                 state_q;
  logic                   fault_q;
  logic [1:0]             fault_src_q;
  logic [NUM_CH-1:0]      st_ch_q;
  logic [SYNC_STAGES-1:0] sync_q;

  logic [NUM_CH-1:0]      hi_q, hi_d;
  logic [NUM_CH-1:0]      lo_q, lo_d;
  logic [1:0]             last_q [NUM_CH];
  logic [1:0]             last_d [NUM_CH];
  logic [DT_W-1:0]        cnt_q  [NUM_CH];
  logic [DT_W-1:0]        cnt_d  [NUM_CH];

  logic                   fault_s;
  logic                   st_s;
  logic [NUM_CH-1:0]      st_req_s;
  logic [NUM_CH-1:0]      tgt_hi_s;
  logic [NUM_CH-1:0]      tgt_lo_s;
  logic                   run_stay_s;
  logic                   run_enter_s;
  logic [DT_W-1:0]        dt_load_s;

  assign fault_s     = ~sync_q[SYNC_STAGES-1];
  assign st_req_s    = hi_i & lo_i;
  assign st_s        = (ST_FAULT != 0) && (|st_req_s);
  assign tgt_hi_s    = hi_i & ~lo_i;
  assign tgt_lo_s    = lo_i & ~hi_i;
  // Counter preload is max(DT,1)-1 so the gap is max(DT,1) cycles.
  assign dt_load_s   = (dt_cycles_i == '0) ? '0 : (dt_cycles_i - DT_W'(1));
  // Channels only drive on an edge where the FSM remains in RUN.
  assign run_stay_s  = (state_q == ST_RUN) && !fault_s && !st_s && en_output_i;
  assign run_enter_s = (state_q == ST_OFF) && !fault_s && en_output_i;

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign state_o     = state_q;
  assign fault_o     = fault_q;
  assign fault_src_o = fault_src_q;
  assign st_ch_o     = st_ch_q;

  // Fault input synchroniser; resets to the "no fault" level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], fault_ni};
    end
  end

  // Run/fault state machine with latched fault cause.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_OFF;
      fault_q     <= 1'b0;
      fault_src_q <= 2'b00;
      st_ch_q     <= '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (fault_s) begin
            state_q     <= ST_FLT;
            fault_q     <= 1'b1;
            fault_src_q <= 2'b01;
          end else if (en_output_i) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Fault outranks a simultaneous enable drop.
          if (fault_s || st_s) begin
            state_q     <= ST_FLT;
            fault_q     <= 1'b1;
            fault_src_q <= {st_s, fault_s};
            st_ch_q     <= st_s ? st_req_s : '0;
          end else if (!en_output_i) begin
            state_q <= ST_OFF;
          end
        end
        ST_FLT: begin
          if (fault_clr_i && !en_output_i && !fault_s) begin
            state_q     <= ST_OFF;
            fault_q     <= 1'b0;
            fault_src_q <= 2'b00;
            st_ch_q     <= '0;
          end
        end
        default: begin
          state_q     <= ST_OFF;
          fault_q     <= 1'b0;
          fault_src_q <= 2'b00;
          st_ch_q     <= '0;
        end
      endcase
    end
  end

  // Per-channel dead-time sequencing: next drive, last side, counter.
  always_comb begin
    hi_d = '0;
    lo_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      last_d[i] = last_q[i];
      cnt_d[i]  = (cnt_q[i] != '0) ? (cnt_q[i] - DT_W'(1)) : '0;
      if (run_stay_s) begin
        if (hi_q[i] && !tgt_hi_s[i]) begin
          last_d[i] = SIDE_HI;
          cnt_d[i]  = dt_load_s;
        end else if (lo_q[i] && !tgt_lo_s[i]) begin
          last_d[i] = SIDE_LO;
          cnt_d[i]  = dt_load_s;
        end else if (hi_q[i]) begin
          hi_d[i] = 1'b1;
        end else if (lo_q[i]) begin
          lo_d[i] = 1'b1;
        end else if (tgt_hi_s[i]) begin
          // Returning to the released side needs no dead time.
          hi_d[i] = (last_q[i] == SIDE_HI) || (cnt_q[i] == '0);
        end else if (tgt_lo_s[i]) begin
          lo_d[i] = (last_q[i] == SIDE_LO) || (cnt_q[i] == '0);
        end else begin
          hi_d[i] = 1'b0;
          lo_d[i] = 1'b0;
        end
      end else if (run_enter_s) begin
        last_d[i] = SIDE_NONE;
        cnt_d[i]  = dt_load_s;
      end else begin
        last_d[i] = last_q[i];
      end
    end
  end

  // Per-channel registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      lo_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        last_q[i] <= SIDE_NONE;
        cnt_q[i]  <= '0;
      end
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      for (int i = 0; i < NUM_CH; i++) begin
        last_q[i] <= last_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_gate_ctrl_dt.sv
// Directed bench for gate_ctrl_dt plus a randomised soak with an
// overlap / dead-time monitor.
module tb_gate_ctrl_dt;
  localparam int NUM_CH = 3;
  localparam int DT_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en_output = 1'b0;
  logic [NUM_CH-1:0] hi_in = '0;
  logic [NUM_CH-1:0] lo_in = '0;
  logic [DT_W-1:0]   dt_cycles = '0;
  logic              fault_n = 1'b1;
  logic              fault_clr = 1'b0;
  logic [NUM_CH-1:0] hi_o, lo_o, st_ch_o;
  logic [1:0]        state_o, fault_src_o;
  logic              fault_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  gate_ctrl_dt #(.NUM_CH(NUM_CH), .DT_W(DT_W), .ST_FAULT(1), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_output_i(en_output), .hi_i(hi_in), .lo_i(lo_in),
    .dt_cycles_i(dt_cycles), .fault_ni(fault_n), .fault_clr_i(fault_clr),
    .hi_o(hi_o), .lo_o(lo_o), .state_o(state_o), .fault_o(fault_o),
    .fault_src_o(fault_src_o), .st_ch_o(st_ch_o)
  );

  always #5 clk = ~clk;

  // Monitor: overlap and dead-time gaps, sampled 1 ns after each rising edge.
  logic              mon_en = 1'b0;
  logic [NUM_CH-1:0] prev_hi = '0, prev_lo = '0;
  int                since [NUM_CH];
  int                side  [NUM_CH];
  int                mon_overlap = 0, mon_viol = 0, mon_opp = 0;
  always begin
    int dtm;
    @(posedge clk);
    #1;
    if (mon_en) begin
      if ((hi_o & lo_o) != '0) mon_overlap++;
      dtm = (dt_cycles == '0) ? 1 : int'(dt_cycles);
      for (int i = 0; i < NUM_CH; i++) begin
        if (lo_o[i] && !prev_lo[i]) begin
          if ((prev_hi[i] && !hi_o[i]) || (side[i] == 1 && since[i] < dtm)) mon_viol++;
          if (side[i] == 1) mon_opp++;
        end
        if (hi_o[i] && !prev_hi[i]) begin
          if ((prev_lo[i] && !lo_o[i]) || (side[i] == 2 && since[i] < dtm)) mon_viol++;
          if (side[i] == 2) mon_opp++;
        end
        if (prev_hi[i] && !hi_o[i]) begin side[i] = 1; since[i] = 1; end
        else if (prev_lo[i] && !lo_o[i]) begin side[i] = 2; since[i] = 1; end
        else if (since[i] < 100000) since[i]++;
      end
    end
    prev_hi = hi_o;
    prev_lo = lo_o;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    chk_cnt++; if (state_o !== 2'b00) $display("FAIL reset_state: got %b want 00", state_o); else pass_cnt++;
    chk_cnt++; if ((hi_o | lo_o) !== 3'b000) $display("FAIL reset_gates: got hi=%b lo=%b want 0", hi_o, lo_o); else pass_cnt++;
    chk_cnt++; if (fault_o !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault_o); else pass_cnt++;
    chk_cnt++; if ({fault_src_o, st_ch_o} !== 5'b00000) $display("FAIL reset_src: got %b/%b want 00/000", fault_src_o, st_ch_o); else pass_cnt++;
  endtask

  task automatic test_run_entry();
    rst_n = 1'b1; en_output = 1'b1; dt_cycles = 8'd4; hi_in = 3'b001; lo_in = 3'b000;
    tick();
    chk_cnt++; if (state_o !== 2'b01) $display("FAIL entry_state: got %b want 01", state_o); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++; if (hi_o !== 3'b000) $display("FAIL entry_wait%0d: got hi=%b want 000", k, hi_o); else pass_cnt++;
      tick();
    end
    chk_cnt++; if (hi_o !== 3'b001 || lo_o !== 3'b000) $display("FAIL entry_drive: got hi=%b lo=%b want 001/000", hi_o, lo_o); else pass_cnt++;
  endtask

  task automatic test_changeover();
    int n;
    dt_cycles = 8'd3; hi_in = 3'b000; lo_in = 3'b001;
    tick();
    chk_cnt++; if (hi_o !== 3'b000 || lo_o !== 3'b000) $display("FAIL co_release: got hi=%b lo=%b want 000/000", hi_o, lo_o); else pass_cnt++;
    n = 1;
    for (int k = 0; k < 20; k++) begin tick(); if (lo_o[0]) break; n++; end
    chk_cnt++; if (n !== 3) $display("FAIL co_gap3: got %0d cycles want 3", n); else pass_cnt++;
    chk_cnt++; if (lo_o !== 3'b001 || hi_o !== 3'b000) $display("FAIL co_drive: got hi=%b lo=%b want 000/001", hi_o, lo_o); else pass_cnt++;
  endtask

  task automatic test_dt_bounds();
    int n;
    dt_cycles = 8'd0; hi_in = 3'b001; lo_in = 3'b000;
    tick();
    chk_cnt++; if ((hi_o | lo_o) !== 3'b000) $display("FAIL dt0_release: got hi=%b lo=%b want 0", hi_o, lo_o); else pass_cnt++;
    n = 1;
    for (int k = 0; k < 20; k++) begin tick(); if (hi_o[0]) break; n++; end
    chk_cnt++; if (n !== 1) $display("FAIL dt0_gap: got %0d cycles want 1", n); else pass_cnt++;
    dt_cycles = 8'd255; hi_in = 3'b000; lo_in = 3'b001;
    tick();
    n = 1;
    for (int k = 0; k < 300; k++) begin
      if (k == 10) dt_cycles = 8'd2;  // must not disturb the running count
      tick(); if (lo_o[0]) break; n++;
    end
    chk_cnt++; if (n !== 255) $display("FAIL dt255_gap: got %0d cycles want 255", n); else pass_cnt++;
  endtask

  task automatic test_same_side();
    dt_cycles = 8'd10; hi_in = 3'b001; lo_in = 3'b000;
    tick();
    chk_cnt++; if ((hi_o | lo_o) !== 3'b000) $display("FAIL same_release: got hi=%b lo=%b want 0", hi_o, lo_o); else pass_cnt++;
    hi_in = 3'b000; lo_in = 3'b001;
    tick();
    chk_cnt++; if (lo_o !== 3'b001 || hi_o !== 3'b000) $display("FAIL same_return: got hi=%b lo=%b want 000/001", hi_o, lo_o); else pass_cnt++;
  endtask

  task automatic test_multi_channel();
    dt_cycles = 8'd2; hi_in = 3'b010; lo_in = 3'b101;
    tick();
    chk_cnt++; if (hi_o !== 3'b010 || lo_o !== 3'b101) $display("FAIL multi_drive: got hi=%b lo=%b want 010/101", hi_o, lo_o); else pass_cnt++;
  endtask

  task automatic test_shoot_through();
    hi_in = 3'b010; lo_in = 3'b011;
    tick();
    chk_cnt++; if ((hi_o | lo_o) !== 3'b000) $display("FAIL st_gates: got hi=%b lo=%b want 0", hi_o, lo_o); else pass_cnt++;
    chk_cnt++; if (state_o !== 2'b10 || fault_o !== 1'b1) $display("FAIL st_state: got %b/%b want 10/1", state_o, fault_o); else pass_cnt++;
    chk_cnt++; if (fault_src_o !== 2'b10 || st_ch_o !== 3'b010) $display("FAIL st_cause: got %b/%b want 10/010", fault_src_o, st_ch_o); else pass_cnt++;
    hi_in = 3'b000; lo_in = 3'b000; fault_clr = 1'b1;
    tick(); fault_clr = 1'b0;
    chk_cnt++; if (state_o !== 2'b10 || fault_src_o !== 2'b10) $display("FAIL st_clr_en: got %b/%b want 10/10", state_o, fault_src_o); else pass_cnt++;
    en_output = 1'b0; fault_clr = 1'b1;
    tick(); fault_clr = 1'b0;
    chk_cnt++; if (state_o !== 2'b00 || fault_o !== 1'b0) $display("FAIL st_clr: got %b/%b want 00/0", state_o, fault_o); else pass_cnt++;
    chk_cnt++; if (fault_src_o !== 2'b00 || st_ch_o !== 3'b000) $display("FAIL st_clr_src: got %b/%b want 00/000", fault_src_o, st_ch_o); else pass_cnt++;
  endtask

  task automatic test_ext_fault();
    int n;
    en_output = 1'b1; dt_cycles = 8'd1; hi_in = 3'b001; lo_in = 3'b000;
    tick(); tick();
    chk_cnt++; if (hi_o !== 3'b001) $display("FAIL ext_pre: got hi=%b want 001", hi_o); else pass_cnt++;
    fault_n = 1'b0;
    tick(); fault_n = 1'b1;
    n = 1;
    while (state_o !== 2'b10 && n < 10) begin tick(); n++; end
    chk_cnt++; if (n !== 3) $display("FAIL ext_latency: got %0d edges want 3", n); else pass_cnt++;
    chk_cnt++; if (hi_o !== 3'b000 || fault_src_o !== 2'b01 || st_ch_o !== 3'b000) $display("FAIL ext_cause: got hi=%b src=%b st=%b want 000/01/000", hi_o, fault_src_o, st_ch_o); else pass_cnt++;
    fault_clr = 1'b1;
    tick(); fault_clr = 1'b0;
    chk_cnt++; if (state_o !== 2'b10) $display("FAIL ext_clr_en: got %b want 10", state_o); else pass_cnt++;
    en_output = 1'b0; hi_in = 3'b000; fault_clr = 1'b1;
    tick(); fault_clr = 1'b0;
    chk_cnt++; if (state_o !== 2'b00 || fault_src_o !== 2'b00) $display("FAIL ext_clr: got %b/%b want 00/00", state_o, fault_src_o); else pass_cnt++;
  endtask

  task automatic test_fault_priority();
    en_output = 1'b1;
    tick();
    en_output = 1'b0; hi_in = 3'b100; lo_in = 3'b100;
    tick();
    chk_cnt++; if (state_o !== 2'b10 || st_ch_o !== 3'b100) $display("FAIL prio_state: got %b/%b want 10/100", state_o, st_ch_o); else pass_cnt++;
    hi_in = 3'b000; lo_in = 3'b000; fault_clr = 1'b1;
    tick(); fault_clr = 1'b0;
    fault_n = 1'b0;
    tick(); tick(); tick();
    chk_cnt++; if (state_o !== 2'b10 || fault_src_o !== 2'b01) $display("FAIL off_fault: got %b/%b want 10/01", state_o, fault_src_o); else pass_cnt++;
    fault_clr = 1'b1;
    tick(); fault_clr = 1'b0;
    chk_cnt++; if (state_o !== 2'b10) $display("FAIL clr_active: got %b want 10", state_o); else pass_cnt++;
    fault_n = 1'b1;
    tick(); tick();
    fault_clr = 1'b1;
    tick(); fault_clr = 1'b0;
    chk_cnt++; if (state_o !== 2'b00) $display("FAIL clr_released: got %b want 00", state_o); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    en_output = 1'b1; dt_cycles = 8'd1; hi_in = 3'b001; lo_in = 3'b000;
    tick(); tick();
    chk_cnt++; if (hi_o !== 3'b001) $display("FAIL arst_pre: got hi=%b want 001", hi_o); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (hi_o !== 3'b000 || state_o !== 2'b00) $display("FAIL arst_clear: got hi=%b state=%b want 000/00", hi_o, state_o); else pass_cnt++;
    en_output = 1'b0; hi_in = 3'b000;
    tick(); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int tgt [NUM_CH];
    logic [DT_W-1:0] dts [6];
    dts[0] = 8'd0; dts[1] = 8'd1; dts[2] = 8'd3; dts[3] = 8'd7; dts[4] = 8'd20; dts[5] = 8'd2;
    for (int i = 0; i < NUM_CH; i++) begin tgt[i] = 3; side[i] = 0; since[i] = 0; end
    mon_en = 1'b1;
    for (int b = 0; b < 6; b++) begin
      en_output = 1'b0; hi_in = '0; lo_in = '0; fault_n = 1'b1; fault_clr = 1'b1;
      repeat (6) tick();
      fault_clr = 1'b0; dt_cycles = dts[b]; en_output = 1'b1;
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < NUM_CH; i++) begin
          int r;
          if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, 99);
            tgt[i] = (r < 45) ? 0 : (r < 90) ? 1 : (r < 99) ? 2 : 3;
          end
          hi_in[i] = (tgt[i] == 0) || (tgt[i] == 3);
          lo_in[i] = (tgt[i] == 1) || (tgt[i] == 3);
          if (tgt[i] == 3) tgt[i] = 2;
        end
        fault_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        if (state_o == 2'b10) begin en_output = 1'b0; fault_clr = 1'b1; end
        else begin fault_clr = 1'b0; en_output = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1; end
        tick();
      end
    end
    mon_en = 1'b0;
    chk_cnt++; if (mon_overlap !== 0) $display("FAIL rnd_overlap: got %0d cycles want 0", mon_overlap); else pass_cnt++;
    chk_cnt++; if (mon_viol !== 0) $display("FAIL rnd_deadtime: got %0d violations want 0", mon_viol); else pass_cnt++;
    chk_cnt++; if (mon_opp < 10) $display("FAIL rnd_activity: got %0d changeovers want >=10", mon_opp); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_run_entry();
    test_changeover();
    test_dt_bounds();
    test_same_side();
    test_multi_channel();
    test_shoot_through();
    test_ext_fault();
    test_fault_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
